// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   PC_W     : program counter / IM address width
//   INSTR_W  : instruction word width
//   IR_RESET : value the instruction register takes on reset
//   fetch_state_e : fetch FSM states
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] IR_RESET = 16'h0000;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,  // no request outstanding
    F_REQ     = 2'd1,  // IM_REQ high, waiting for IM_ACK
    F_DISCARD = 2'd2   // request outstanding but its target is stale
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry instruction buffer: one tagged word plus a valid flag.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset (valid only)
//   wr_en/wr_tag/wr_data : capture a returned word under its address tag
//   rd_tag -> rd_hit, rd_data : lookup for the current PC
//   probe_tag -> probe_hit    : lookup for the upcoming fetch target
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [PC_W-1:0]    wr_tag,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [PC_W-1:0]    rd_tag,
  output logic               rd_hit,
  output logic [INSTR_W-1:0] rd_data,
  input  logic [PC_W-1:0]    probe_tag,
  output logic               probe_hit
);

  logic               buf_valid;
  logic [PC_W-1:0]    buf_tag;
  logic [INSTR_W-1:0] buf_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
    end else if (wr_en) begin
      buf_valid <= 1'b1;
    end
  end

  // Tag and data are only meaningful while buf_valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_tag  <= wr_tag;
      buf_data <= wr_data;
    end
  end

  assign rd_hit    = buf_valid && (buf_tag == rd_tag);
  assign rd_data   = buf_data;
  assign probe_hit = buf_valid && (buf_tag == probe_tag);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, instruction register and the instruction-memory
// request FSM, backed by a one-word tagged buffer (fetch_buffer).
// Ports:
//   Clock, Reset (async, active-low)
//   PC_CLR, PC_IC, IR_LD     : control-unit commands
//   IR, IR_VALID, STALL, PC  : state presented to the control unit
//   IM_REQ, IM_ADDR, IM_ACK, IM_RDATA : instruction-memory read handshake
// Build option: define FETCH_PREFETCH_EN to move the fetch target to PC+1 once
// the word for PC has been consumed, so a following PC_IC hits the buffer.
module instr_fetch
  import fetch_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               PC_CLR,
  input  logic               PC_IC,
  input  logic               IR_LD,
  output logic [INSTR_W-1:0] IR,
  output logic               IR_VALID,
  output logic               STALL,
  output logic [PC_W-1:0]    PC,
  output logic               IM_REQ,
  output logic [PC_W-1:0]    IM_ADDR,
  input  logic               IM_ACK,
  input  logic [INSTR_W-1:0] IM_RDATA
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_e       state;
  logic [PC_W-1:0]    pend_addr;   // PC the stalled IR_LD is waiting for

  logic               rd_hit;
  logic [INSTR_W-1:0] rd_data;
  logic               probe_hit;
  logic               buf_wr;

  logic               pc_chg;
  logic [PC_W-1:0]    pc_nxt;
  logic               ack_live;
  logic               ld_new;
  logic               ld_hit;
  logic               ld_direct;
  logic               ld_miss;
  logic               stall_done;
  logic               stall_nxt;
  logic [PC_W-1:0]    pend_nxt;
  logic               consume;
  logic               pf_nxt;
  logic [PC_W-1:0]    next_tgt;

  // Only a live request writes the buffer; data returned in F_DISCARD is dropped.
  assign buf_wr = (state == F_REQ) && IM_ACK;

  fetch_buffer u_buf (
    .clk       (Clock),
    .rst_n     (Reset),
    .wr_en     (buf_wr),
    .wr_tag    (IM_ADDR),
    .wr_data   (IM_RDATA),
    .rd_tag    (PC),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .probe_tag (next_tgt),
    .probe_hit (probe_hit)
  );

  assign pc_chg = PC_CLR || PC_IC;
  assign pc_nxt = PC_CLR ? '0 : (PC_IC ? PC + PC_ONE : PC);

  assign ack_live = buf_wr;

  // IR_LD while already stalled is redundant and ignored.
  assign ld_new    = IR_LD && !STALL;
  assign ld_hit    = ld_new && rd_hit;
  // The word for PC is arriving this very cycle: take it instead of stalling.
  assign ld_direct = ld_new && !rd_hit && ack_live && (IM_ADDR == PC);
  assign ld_miss   = ld_new && !rd_hit && !ld_direct;

  // A PC change while stalled cancels the load; otherwise the matching ACK completes it.
  assign stall_done = STALL && !pc_chg && ack_live && (IM_ADDR == pend_addr);
  assign stall_nxt  = ld_miss || (STALL && !pc_chg && !stall_done);
  assign pend_nxt   = ld_miss ? PC : pend_addr;
  assign consume    = ld_hit || ld_direct || stall_done;

`ifdef FETCH_PREFETCH_EN
  logic pf;  // word for PC already consumed: fetch PC+1 next

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pf <= 1'b0;
    end else begin
      pf <= pf_nxt;
    end
  end

  assign pf_nxt = pc_chg ? 1'b0 : (consume ? 1'b1 : pf);
`else
  assign pf_nxt = 1'b0;
`endif

  // Target as it will stand after this edge; a pending stall always has priority.
  assign next_tgt = stall_nxt ? pend_nxt : (pf_nxt ? pc_nxt + PC_ONE : pc_nxt);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= F_IDLE;
      IM_REQ    <= 1'b0;
      IM_ADDR   <= '0;
      PC        <= '0;
      IR        <= IR_RESET;
      IR_VALID  <= 1'b0;
      STALL     <= 1'b0;
      pend_addr <= '0;
    end else begin
      PC        <= pc_nxt;
      STALL     <= stall_nxt;
      pend_addr <= pend_nxt;

      if (ld_hit) begin
        IR       <= rd_data;
        IR_VALID <= 1'b1;
      end else if (ld_direct || stall_done) begin
        IR       <= IM_RDATA;
        IR_VALID <= 1'b1;
      end

      case (state)
        F_IDLE: begin
          if (!probe_hit) begin
            state   <= F_REQ;
            IM_REQ  <= 1'b1;
            IM_ADDR <= next_tgt;
          end
        end
        F_REQ: begin
          // IM_ADDR must stay put until the ACK, even if the target moved on.
          if (IM_ACK) begin
            state  <= F_IDLE;
            IM_REQ <= 1'b0;
          end else if (next_tgt != IM_ADDR) begin
            state <= F_DISCARD;
          end
        end
        F_DISCARD: begin
          if (IM_ACK) begin
            state  <= F_IDLE;
            IM_REQ <= 1'b0;
          end
        end
        default: begin
          state  <= F_IDLE;
          IM_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule
